// File: rtl/systolic_tile_ctrl.sv
// systolic_tile_ctrl
//   Sequencer for one ROWS x COLS weight-stationary systolic tile of signed
//   8-bit MAC PEs. A job loads ROWS weight rows, streams n_vec activation
//   vectors, then drains the skewed pipeline. A LAT-deep token shift register
//   follows each issued vector to the bottom edge and raises out_valid there.
// Ports
//   clk, rst_n            clock (rising) / async active-low reset
//   start, n_vec,         job request (IDLE only); vector count and 4-bit
//   quant_in              quantize mode are captured with it
//   stall                 back-pressure; freezes STREAM/DRAIN in the same cycle
//   abort                 cancel the current job, return to IDLE, no done
//   wt_rd_en/wt_rd_addr   weight buffer read port
//   load_weight           one-hot per-row weight capture strobe
//   act_rd_en/act_rd_addr activation buffer read port
//   pe_enable, quant_mode PE array controls
//   out_valid             bottom-edge psums valid this cycle
//   busy, done            job status; done is a 1-cycle pulse
module systolic_tile_ctrl #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int VEC_W = 10,
  parameter int LAT   = ROWS + COLS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [VEC_W-1:0]        n_vec,
  input  logic                    quant_in,
  input  logic                    stall,
  input  logic                    abort,
  output logic                    wt_rd_en,
  output logic [$clog2(ROWS)-1:0] wt_rd_addr,
  output logic [ROWS-1:0]         load_weight,
  output logic                    act_rd_en,
  output logic [VEC_W-1:0]        act_rd_addr,
  output logic                    pe_enable,
  output logic                    quant_mode,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    done
);
  localparam int RW = $clog2(ROWS + 1);
  localparam int AW = $clog2(ROWS);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

  state_t           state;
  logic [RW-1:0]    r;
  logic [VEC_W-1:0] v;
  logic [VEC_W-1:0] n_q;
  logic [LAT-1:0]   tok;   // tok[0] = newest issue, tok[LAT-1] = at bottom edge

  // stall gates the datapath combinationally in the cycle it is seen.
  assign act_rd_en   = (state == STREAM) && !stall;
  assign pe_enable   = ((state == STREAM) || (state == DRAIN)) && !stall;
  assign out_valid   = tok[LAT-1] && pe_enable;
  assign act_rd_addr = v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      r           <= '0;
      v           <= '0;
      n_q         <= '0;
      tok         <= '0;
      wt_rd_en    <= 1'b0;
      wt_rd_addr  <= '0;
      load_weight <= '0;
      quant_mode  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (state != IDLE && abort) begin
      state       <= IDLE;
      r           <= '0;
      v           <= '0;
      tok         <= '0;
      wt_rd_en    <= 1'b0;
      load_weight <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      // Tokens move only with the PE array so they stay aligned with data.
      if (pe_enable) tok <= {tok[LAT-2:0], state == STREAM};
      case (state)
        IDLE: if (start) begin
          state      <= LOAD_W;
          n_q        <= n_vec;
          quant_mode <= quant_in;
          r          <= '0;
          v          <= '0;
          wt_rd_en   <= 1'b1;
          wt_rd_addr <= '0;
          busy       <= 1'b1;
        end
        LOAD_W: begin
          // Row r is read this cycle; its capture strobe follows next cycle.
          r           <= r + 1'b1;
          wt_rd_en    <= (r < RW'(ROWS - 1));
          wt_rd_addr  <= AW'(r + 1'b1);
          load_weight <= (r < RW'(ROWS)) ? (ROWS'(1) << r) : '0;
          if (r == RW'(ROWS)) begin
            load_weight <= '0;
            if (n_q == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: if (!stall) begin
          // v stops at n_q-1 so the address never passes the last vector.
          if (v == n_q - 1'b1) state <= DRAIN;
          else                 v     <= v + 1'b1;
        end
        DRAIN: if (!stall && tok[LAT-2:0] == '0) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
